step_clock_gen: RTL
===================

Name: step_clock_gen

Overview:
- Generates the CPU single-step clock (`step_clk`) from the board push-button on the board system clock.
- Sits directly upstream of the cpu instance: `step_clk` drives `cpu.clock`, and `ticks` feeds the display/debug path.
- Adds proper synchronisation, debounce, one pulse per press, and an optional auto-run mode that free-runs the CPU at a divided rate.

Parameters:
- DEBOUNCE_CYCLES, 5000, consecutive stable cycles required before the debounced button changes (>=1).
- STEP_HIGH, 5000, number of clk cycles `step_clk` stays high per step (>=1).
- AUTO_DIV, 50000000, clk cycles between auto-run steps (>= STEP_HIGH+2).
- CNT_W, 26, width of the internal counters; must hold max(DEBOUNCE_CYCLES, STEP_HIGH, AUTO_DIV).

Ports:
- clk  input  1  board system clock; the only clock in the block.
- reset  input  1  synchronous, active-high reset.
- button  input  1  raw, asynchronous, bouncing push-button.
- auto_en  input  1  1 = auto-run mode (button ignored); 0 = manual single-step.
- step_clk  output  1  registered CPU step clock.
- step_pulse  output  1  one-cycle strobe in the cycle `step_clk` first goes high.
- ticks  output  8  count of steps issued since reset; wraps.
- busy  output  1  high while state != IDLE.

Behaviour:
- Reset (sampled at a clk edge with reset=1):
  - `step_clk`=0, `step_pulse`=0, `ticks`=0, `busy`=0.
  - Sync flops=0, debounced button `btn_db`=0, all counters=0, state=IDLE.
  - Reset mid-pulse forces `step_clk` low at that same edge; no partial pulse resumes afterwards.
- Synchroniser: `button` → s1 → s2, two flops.
- Debounce:
  - If s2 != `btn_db`, the counter increments; otherwise the counter clears to 0.
  - When the counter reaches DEBOUNCE_CYCLES-1 while still differing: `btn_db` <= s2 and the counter clears.
  - A glitch shorter than DEBOUNCE_CYCLES cycles never changes `btn_db`.
- FSM states IDLE, HIGH, WAIT_REL:
  - IDLE → HIGH on trigger:
    - Manual mode (`auto_en`=0): trigger is `btn_db`=1.
    - Auto mode (`auto_en`=1): trigger is the auto counter at AUTO_DIV-1.
  - On entering HIGH: `step_clk`<=1, `step_pulse`<=1 for exactly one cycle, `ticks`<=`ticks`+1 (255 wraps to 0), high counter<=0.
  - HIGH: the high counter increments each cycle. When it equals STEP_HIGH-1: `step_clk`<=0 and state → WAIT_REL. `step_clk` is therefore high for exactly STEP_HIGH cycles.
  - WAIT_REL → IDLE when `btn_db`=0 or `auto_en`=1. Holding the button yields exactly one step.
- Auto counter:
  - Counts 0..AUTO_DIV-1 and wraps while `auto_en`=1; held at 0 while `auto_en`=0.
  - A terminal count reached while not in IDLE is dropped; steps never queue.
- Mode changes:
  - Toggling `auto_en` during HIGH does not shorten or extend the pulse.
  - A button press while `auto_en`=1 is ignored. It is not remembered after `auto_en` falls unless `btn_db` is still 1, in which case IDLE triggers normally.
- Latency (manual): `button` high and stable from edge k gives `btn_db`=1 after edge k+1+DEBOUNCE_CYCLES and `step_clk`=1 after edge k+2+DEBOUNCE_CYCLES.
- Outputs:
  - All outputs are registered; no combinational path from inputs to outputs.
  - `busy` = (state != IDLE), registered alongside the state.

Decomposition:
- Package step_pkg:
  - State enum {IDLE, HIGH, WAIT_REL}.
  - Default parameter constants.
- Sub-module btn_debounce:
  - Contains the synchroniser and debounce counter.
  - Parameter DEBOUNCE_CYCLES; ports clk, reset, din, dout.
- The FSM, auto counter and ticks live in step_clock_gen.

Test Plan (parameters DEBOUNCE_CYCLES=4, STEP_HIGH=3, AUTO_DIV=10):
- Clean press: `button`=1 from edge 10, held for 20 cycles → `step_clk`=1 after edges 16,17,18 only; `step_pulse`=1 only after edge 16; `ticks`=1; exactly one pulse.
- Bounce: `button` toggles 1,0,1,0 every cycle for 8 cycles, then 0 → `btn_db` never rises; `step_clk` stays 0; `ticks`=0.
- Repeated presses: 3 clean presses, each 10 cycles high and 10 low → 3 pulses, each 3 cycles wide; `ticks`=3.
- Auto-run: `auto_en`=1 for 40 cycles with `button` held at 1 → a pulse every 10 cycles (4 pulses); the button has no extra effect; `ticks`=4.
- Wrap and reset: issue 256 auto steps → `ticks`=0. Then assert reset for 1 cycle mid-HIGH → `step_clk`=0 and `ticks`=0 after that edge; `busy`=0; the next step needs a fresh trigger.

Source files
------------

// File: rtl/step_pkg.sv
// Shared types and default sizing for the single-step clock generator.
package step_pkg;

    typedef enum logic [1:0] {
        IDLE,
        HIGH,
        WAIT_REL
    } step_state_e;

    localparam int DEF_DEBOUNCE_CYCLES = 5000;
    localparam int DEF_STEP_HIGH       = 5000;
    localparam int DEF_AUTO_DIV        = 50000000;
    localparam int DEF_CNT_W           = 26;

endpackage

// File: rtl/btn_debounce.sv
// Two-flop synchroniser followed by a stable-time debounce filter.
// The output only follows the input after it has stayed different for DEBOUNCE_CYCLES cycles.
module btn_debounce
    import step_pkg::*;
#(
    parameter int DEBOUNCE_CYCLES = DEF_DEBOUNCE_CYCLES,
    parameter int CNT_W           = DEF_CNT_W
) (
    input  logic clk,
    input  logic reset,
    input  logic din,
    output logic dout
);

    localparam logic [CNT_W-1:0] CNT_LAST = CNT_W'(DEBOUNCE_CYCLES - 1);

    logic             s1_q;
    logic             s2_q;
    logic             db_q;
    logic             db_d;
    logic [CNT_W-1:0] cnt_q;
    logic [CNT_W-1:0] cnt_d;

    always_comb begin
        // NOTE: defaults first, so every path assigns every output and no latch is inferred.
        db_d  = db_q;
        cnt_d = '0;
        if (s2_q != db_q) begin
            if (cnt_q == CNT_LAST) begin
                db_d = s2_q;
            end else begin
                cnt_d = cnt_q + CNT_W'(1);
            end
        end
    end

    always_ff @(posedge clk) begin
        // NOTE: non-blocking assignments so every flop samples pre-edge values.
        if (reset) begin
            s1_q  <= 1'b0;
            s2_q  <= 1'b0;
            db_q  <= 1'b0;
            cnt_q <= '0;
        end else begin
            s1_q  <= din;
            s2_q  <= s1_q;
            db_q  <= db_d;
            cnt_q <= cnt_d;
        end
    end

    assign dout = db_q;

endmodule

// File: rtl/step_clock_gen.sv
// CPU single-step clock: one STEP_HIGH-cycle pulse per debounced press,
// or a free-running step every AUTO_DIV cycles while auto_en is high.
module step_clock_gen
    import step_pkg::*;
#(
    parameter int DEBOUNCE_CYCLES = DEF_DEBOUNCE_CYCLES,
    parameter int STEP_HIGH       = DEF_STEP_HIGH,
    parameter int AUTO_DIV        = DEF_AUTO_DIV,
    parameter int CNT_W           = DEF_CNT_W
) (
    input  logic       clk,
    input  logic       reset,
    input  logic       button,
    input  logic       auto_en,
    output logic       step_clk,
    output logic       step_pulse,
    output logic [7:0] ticks,
    output logic       busy
);

    localparam logic [CNT_W-1:0] HIGH_LAST = CNT_W'(STEP_HIGH - 1);
    localparam logic [CNT_W-1:0] AUTO_LAST = CNT_W'(AUTO_DIV - 1);

    logic             btn_db;
    step_state_e      state_q;
    step_state_e      state_d;
    logic             step_clk_q;
    logic             step_clk_d;
    logic             pulse_q;
    logic             pulse_d;
    logic             busy_q;
    logic             busy_d;
    logic [7:0]       ticks_q;
    logic [7:0]       ticks_d;
    logic [CNT_W-1:0] high_cnt_q;
    logic [CNT_W-1:0] high_cnt_d;
    logic [CNT_W-1:0] auto_cnt_q;
    logic [CNT_W-1:0] auto_cnt_d;
    logic             auto_tc;
    logic             trigger;

    btn_debounce #(
        .DEBOUNCE_CYCLES(DEBOUNCE_CYCLES),
        .CNT_W          (CNT_W)
    ) u_debounce (
        .clk  (clk),
        .reset(reset),
        .din  (button),
        .dout (btn_db)
    );

    // The auto counter free-runs; a terminal count outside IDLE is simply lost.
    always_comb begin
        auto_tc    = auto_en && (auto_cnt_q == AUTO_LAST);
        trigger    = auto_en ? auto_tc : btn_db;
        auto_cnt_d = '0;
        if (auto_en && !auto_tc) begin
            auto_cnt_d = auto_cnt_q + CNT_W'(1);
        end
    end

    always_comb begin
        state_d    = state_q;
        step_clk_d = step_clk_q;
        pulse_d    = 1'b0;
        ticks_d    = ticks_q;
        high_cnt_d = high_cnt_q;
        unique case (state_q)
            IDLE: begin
                if (trigger) begin
                    state_d    = HIGH;
                    step_clk_d = 1'b1;
                    pulse_d    = 1'b1;
                    ticks_d    = ticks_q + 8'd1;
                    high_cnt_d = '0;
                end
            end
            HIGH: begin
                if (high_cnt_q == HIGH_LAST) begin
                    state_d    = WAIT_REL;
                    step_clk_d = 1'b0;
                end else begin
                    high_cnt_d = high_cnt_q + CNT_W'(1);
                end
            end
            WAIT_REL: begin
                // Leaving only on release is what makes a held button a single step.
                if (!btn_db || auto_en) begin
                    state_d = IDLE;
                end
            end
            default: begin
                state_d    = IDLE;
                step_clk_d = 1'b0;
            end
        endcase
        busy_d = (state_d != IDLE);
    end

    always_ff @(posedge clk) begin
        if (reset) begin
            state_q    <= IDLE;
            step_clk_q <= 1'b0;
            pulse_q    <= 1'b0;
            busy_q     <= 1'b0;
            ticks_q    <= '0;
            high_cnt_q <= '0;
            auto_cnt_q <= '0;
        end else begin
            state_q    <= state_d;
            step_clk_q <= step_clk_d;
            pulse_q    <= pulse_d;
            busy_q     <= busy_d;
            ticks_q    <= ticks_d;
            high_cnt_q <= high_cnt_d;
            auto_cnt_q <= auto_cnt_d;
        end
    end

    assign step_clk   = step_clk_q;
    assign step_pulse = pulse_q;
    assign ticks      = ticks_q;
    assign busy       = busy_q;

endmodule
